// File: rtl/pll_reconfig_pkg.sv
// Shared constants, state encoding and data-word helpers for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

    // altera_pll_reconfig register addresses
    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;

    // Counter-word field offsets
    localparam int FLD_LO   = 0;
    localparam int FLD_HI   = 8;
    localparam int FLD_BYP  = 16;
    localparam int FLD_ODD  = 17;
    localparam int FLD_CIDX = 18;
    localparam int WORD_W   = 18;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C,
        ST_WR_START,
        ST_WAIT_RCFG,
        ST_WAIT_LOCK,
        ST_FIN
    } state_e;

    // N/M write data: the counter word zero-extended to the bus width
    function automatic logic [31:0] nm_data(input logic [WORD_W-1:0] word);
        nm_data = {14'd0, word};
    endfunction

    // C write data: counter word with the channel index placed above it
    function automatic logic [31:0] c_data(input logic [4:0] k, input logic [WORD_W-1:0] word);
        c_data                  = 32'd0;
        c_data[WORD_W-1:0]      = word;
        c_data[FLD_CIDX +: 5]   = k;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into the refclk domain.
module pll_reconfig_seq_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes MODE, N, M, selected C counters and START over the
// Avalon-MM mgmt port, polls for reconfig completion, then waits for the PLL to relock.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_CLK      = 2,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int TMO_W        = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                      refclk_i,
    input  logic                      rst_i,
    input  logic                      cfg_start_i,
    input  logic [WORD_W-1:0]         cfg_n_i,
    input  logic [WORD_W-1:0]         cfg_m_i,
    input  logic [WORD_W*NUM_CLK-1:0] cfg_c_i,
    input  logic [NUM_CLK-1:0]        cfg_cmask_i,
    output logic                      cfg_busy_o,
    output logic                      cfg_done_o,
    output logic                      cfg_err_o,
    input  logic                      pll_locked_i,
    output logic [5:0]                mgmt_address_o,
    output logic                      mgmt_write_o,
    output logic [31:0]               mgmt_writedata_o,
    input  logic                      mgmt_waitrequest_i
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic [4:0]                k_q, k_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      seen0_q, seen0_d;
    logic [3:0]                hi_cnt_q, hi_cnt_d;
    logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                      write_q, write_d;
    logic [5:0]                addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [WORD_W-1:0]         n_q, m_q;
    logic [WORD_W*NUM_CLK-1:0] c_q;
    logic [NUM_CLK-1:0]        cmask_q;
    logic                      latch_s, xfer_s, tmo_hit_s, locked_s;
    logic [5:0]                first_ch_s, next_ch_s;

    // Lowest enabled channel at or above 'from'; bit 5 flags that one exists
    function automatic logic [5:0] find_ch(input logic [NUM_CLK-1:0] mask, input logic [4:0] from);
        find_ch = 6'd0;
        for (int i = NUM_CLK - 1; i >= 0; i--) begin
            if (mask[i] && (5'(i) >= from)) begin
                find_ch = {1'b1, 5'(i)};
            end
        end
    endfunction

    // Counter word of channel k from the latched C bus
    function automatic logic [WORD_W-1:0] sel_c(input logic [WORD_W*NUM_CLK-1:0] c, input logic [4:0] k);
        sel_c = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (5'(i) == k) begin
                sel_c = c[i*WORD_W +: WORD_W];
            end
        end
    endfunction

    pll_reconfig_seq_sync2 u_lock_sync (
        .clk_i (refclk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (locked_s)
    );

    // Next-state, channel walk, lock qualification, timeout and next output values
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        err_d      = err_q;
        seen0_d    = seen0_q;
        hi_cnt_d   = hi_cnt_q;
        latch_s    = 1'b0;
        xfer_s     = write_q & ~mgmt_waitrequest_i;
        tmo_hit_s  = (tmo_q == TMO_LAST);
        first_ch_s = find_ch(cmask_q, 5'd0);
        next_ch_s  = find_ch(cmask_q, k_q + 5'd1);

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    state_d = ST_WR_MODE;
                    err_d   = 1'b0;
                    latch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_MODE, ST_WR_N, ST_WR_START, ST_WAIT_RCFG: begin
                if (xfer_s) begin
                    case (state_q)
                        ST_WR_MODE:  state_d = ST_WR_N;
                        ST_WR_N:     state_d = ST_WR_M;
                        ST_WR_START: state_d = ST_WAIT_RCFG;
                        default:     state_d = ST_WAIT_LOCK;
                    endcase
                end else if (tmo_hit_s) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_M: begin
                if (xfer_s) begin
                    state_d = first_ch_s[5] ? ST_WR_C : ST_WR_START;
                    k_d     = first_ch_s[4:0];
                end else if (tmo_hit_s) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WR_M;
                end
            end
            ST_WR_C: begin
                if (xfer_s) begin
                    state_d = next_ch_s[5] ? ST_WR_C : ST_WR_START;
                    k_d     = next_ch_s[5] ? next_ch_s[4:0] : k_q;
                end else if (tmo_hit_s) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WR_C;
                end
            end
            ST_WAIT_LOCK: begin
                // A PLL that relocked before we looked never shows a 0, so accept 16 steady highs too
                seen0_d  = seen0_q | ~locked_s;
                hi_cnt_d = locked_s ? (hi_cnt_q + 4'd1) : 4'd0;
                if (locked_s && (seen0_q || (hi_cnt_q == 4'd15))) begin
                    state_d = ST_FIN;
                end else if (tmo_hit_s) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Lock qualifiers start fresh on every entry to WAIT_LOCK
        if (state_d != ST_WAIT_LOCK) begin
            seen0_d  = 1'b0;
            hi_cnt_d = 4'd0;
        end else begin
            seen0_d  = seen0_d;
        end

        // Timeout restarts whenever a new write or wait phase begins
        if ((state_q == ST_IDLE) || (state_d != state_q) || (k_d != k_q)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        write_d = 1'b0;
        addr_d  = ADDR_MODE;
        wdata_d = 32'd0;
        case (state_d)
            ST_WR_MODE, ST_WAIT_RCFG: begin
                write_d = 1'b1;
                addr_d  = ADDR_MODE;
            end
            ST_WR_N: begin
                write_d = 1'b1;
                addr_d  = ADDR_N;
                wdata_d = nm_data(n_q);
            end
            ST_WR_M: begin
                write_d = 1'b1;
                addr_d  = ADDR_M;
                wdata_d = nm_data(m_q);
            end
            ST_WR_C: begin
                write_d = 1'b1;
                addr_d  = ADDR_C;
                wdata_d = c_data(k_d, sel_c(c_q, k_d));
            end
            ST_WR_START: begin
                write_d = 1'b1;
                addr_d  = ADDR_START;
            end
            default: begin
                write_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State, latched request and registered bus/handshake outputs
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            k_q      <= 5'd0;
            tmo_q    <= '0;
            seen0_q  <= 1'b0;
            hi_cnt_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= 6'd0;
            wdata_q  <= 32'd0;
            n_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            cmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            tmo_q    <= tmo_d;
            seen0_q  <= seen0_d;
            hi_cnt_q <= hi_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            if (latch_s) begin
                n_q     <= cfg_n_i;
                m_q     <= cfg_m_i;
                c_q     <= cfg_c_i;
                cmask_q <= cfg_cmask_i;
            end
        end
    end

    assign cfg_busy_o       = busy_q;
    assign cfg_done_o       = done_q;
    assign cfg_err_o        = err_q;
    assign mgmt_write_o     = write_q;
    assign mgmt_address_o   = addr_q;
    assign mgmt_writedata_o = wdata_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected bus writes and done/err outcomes are queued
// from a simple model of the register-write sequence; a monitor checks what the DUT presents.
module tb_pll_reconfig_seq;

    localparam int NUM_CLK      = 2;
    localparam int LOCK_TIMEOUT = 100;

    logic                  refclk = 1'b0;
    logic                  rst;
    logic                  cfg_start;
    logic [17:0]           cfg_n, cfg_m;
    logic [18*NUM_CLK-1:0] cfg_c;
    logic [NUM_CLK-1:0]    cfg_cmask;
    logic                  cfg_busy, cfg_done, cfg_err;
    logic                  pll_locked;
    logic [5:0]            mgmt_address;
    logic                  mgmt_write;
    logic [31:0]           mgmt_writedata;
    logic                  mgmt_waitrequest;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        bit          poll;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  lock_entry = 0;
    int  n3_cycles = 0;
    int  done_count = 0;
    bit  exp_err = 1'b0;
    int  exp_lat = -1;
    int  stall_mode = 0;
    int  n_stall = 0;

    pll_reconfig_seq #(
        .NUM_CLK      (NUM_CLK),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .refclk_i           (refclk),
        .rst_i              (rst),
        .cfg_start_i        (cfg_start),
        .cfg_n_i            (cfg_n),
        .cfg_m_i            (cfg_m),
        .cfg_c_i            (cfg_c),
        .cfg_cmask_i        (cfg_cmask),
        .cfg_busy_o         (cfg_busy),
        .cfg_done_o         (cfg_done),
        .cfg_err_o          (cfg_err),
        .pll_locked_i       (pll_locked),
        .mgmt_address_o     (mgmt_address),
        .mgmt_write_o       (mgmt_write),
        .mgmt_writedata_o   (mgmt_writedata),
        .mgmt_waitrequest_i (mgmt_waitrequest)
    );

    always #5 refclk = ~refclk;

    // Cycle counter used to time the lock phase
    always @(posedge refclk) cyc <= cyc + 1;

    // Waitrequest generator: none, random, or a 3-cycle stall on the N write
    initial begin
        mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge refclk);
            #1;
            if (stall_mode == 1) begin
                mgmt_waitrequest = ($urandom_range(0, 3) == 0);
            end else if (stall_mode == 2 && mgmt_write && mgmt_address == 6'd3 && n_stall < 3) begin
                mgmt_waitrequest = 1'b1;
                n_stall++;
            end else begin
                mgmt_waitrequest = 1'b0;
            end
            if (!(mgmt_write && mgmt_address == 6'd3)) n_stall = 0;
        end
    end

    // Monitor: every presented write must match the head of the queue; done must match outcome
    always @(negedge refclk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (mgmt_write) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write",
                             mgmt_address, mgmt_writedata);
                end else begin
                    if (mgmt_address !== exp_q[0].addr || mgmt_writedata !== exp_q[0].data) begin
                        fails++;
                        $display("FAIL bus_write: got (%0d,0x%0h), required (%0d,0x%0h)",
                                 mgmt_address, mgmt_writedata, exp_q[0].addr, exp_q[0].data);
                    end
                    if (!mgmt_waitrequest) begin
                        if (exp_q[0].poll) lock_entry = cyc + 1;
                        void'(exp_q.pop_front());
                    end
                end
                if (mgmt_address == 6'd3) n3_cycles++;
            end
            if (cfg_done) begin
                done_count++;
                tests++;
                if (cfg_err !== exp_err) begin
                    fails++;
                    $display("FAIL done_err: got %0b, required %0b", cfg_err, exp_err);
                end
                tests++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL writes_before_done: got %0d outstanding, required 0", exp_q.size());
                end
                if (exp_lat >= 0) begin
                    tests++;
                    if (cyc - lock_entry != exp_lat) begin
                        fails++;
                        $display("FAIL lock_latency: got %0d cycles, required %0d", cyc - lock_entry, exp_lat);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    // Model of the write sequence for one request
    task automatic push_expected(input logic [17:0] n, input logic [17:0] m,
                                 input logic [18*NUM_CLK-1:0] c, input logic [NUM_CLK-1:0] mask);
        exp_q.push_back('{6'd0, 32'd0, 1'b0});
        exp_q.push_back('{6'd3, 32'(n), 1'b0});
        exp_q.push_back('{6'd4, 32'(m), 1'b0});
        for (int k = 0; k < NUM_CLK; k++) begin
            if (mask[k]) exp_q.push_back('{6'd5, (32'(k) << 18) + 32'(c[k*18 +: 18]), 1'b0});
        end
        exp_q.push_back('{6'd2, 32'd0, 1'b0});
        exp_q.push_back('{6'd0, 32'd0, 1'b1});
    endtask

    // One full request. lmode: 0 lock held high, 1 lock drops then returns, 2 lock stuck low
    task automatic run_seq(input logic [17:0] n, input logic [17:0] m, input logic [18*NUM_CLK-1:0] c,
                           input logic [NUM_CLK-1:0] mask, input int lmode, input int smode, input bit poke);
        int  rise_at;
        int  n3_before;
        int  dc_before;
        bit  got;
        stall_mode = smode;
        pll_locked = 1'b1;
        exp_err    = (lmode == 2);
        exp_lat    = (lmode == 0) ? 16 : ((lmode == 2) ? LOCK_TIMEOUT : -1);
        push_expected(n, m, c, mask);
        cfg_n     = n;
        cfg_m     = m;
        cfg_c     = c;
        cfg_cmask = mask;
        cfg_start = 1'b1;
        n3_before = n3_cycles;
        dc_before = done_count;
        @(posedge refclk);
        #1;
        cfg_start = 1'b0;
        check("busy_after_accept", 64'(cfg_busy), 64'd1);
        check("err_cleared_on_accept", 64'(cfg_err), 64'd0);
        if (lmode != 0) pll_locked = 1'b0;
        rise_at = $urandom_range(2, 60);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (lmode == 1 && i == rise_at) pll_locked = 1'b1;
            if (poke && i == 2) begin
                cfg_start = 1'b1;
                cfg_n     = ~n;
                cfg_cmask = ~mask;
            end else begin
                cfg_start = 1'b0;
            end
            @(posedge refclk);
            #1;
            got = (done_count != dc_before);
        end
        cfg_start = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no cfg_done within 3000 cycles, required one");
        end
        check("busy_after_done", 64'(cfg_busy), 64'd0);
        if (smode == 2) check("n_write_stall_cycles", 64'(n3_cycles - n3_before), 64'd4);
        if (smode == 0) check("n_write_cycles", 64'(n3_cycles - n3_before), 64'd1);
        @(posedge refclk);
        #1;
        check("idle_no_write", 64'(mgmt_write), 64'd0);
    endtask

    initial begin
        logic [17:0]           n, m;
        logic [18*NUM_CLK-1:0] c;
        bit                    found;

        rst        = 1'b1;
        cfg_start  = 1'b1;
        cfg_n      = 18'h3FFFF;
        cfg_m      = 18'h3FFFF;
        cfg_c      = '1;
        cfg_cmask  = '1;
        pll_locked = 1'b0;

        // Reset held with a pending start: every output stays 0
        for (int i = 0; i < 3; i++) begin
            @(posedge refclk);
            #1;
            check("reset_outputs",
                  {23'd0, cfg_busy, cfg_done, cfg_err, mgmt_write, mgmt_address, mgmt_writedata},
                  64'd0);
        end
        rst       = 1'b0;
        cfg_start = 1'b0;
        @(posedge refclk);
        #1;
        check("idle_after_reset", {62'd0, cfg_busy, mgmt_write}, 64'd0);

        // Reference sequence, no stalls, lock held high
        run_seq(18'h20302, 18'h01818, {18'h20302, 18'h00505}, 2'b11, 0, 0, 1'b0);
        // 3-cycle stall on N
        run_seq(18'h20302, 18'h01818, {18'h20302, 18'h00505}, 2'b11, 1, 2, 1'b0);
        // Mask variants
        run_seq(18'h00101, 18'h10203, {18'h20302, 18'h00505}, 2'b10, 1, 0, 1'b0);
        run_seq(18'h00101, 18'h10203, {18'h20302, 18'h00505}, 2'b00, 0, 0, 1'b0);
        // Lock timeout, then a request that must clear err
        run_seq(18'h01111, 18'h02222, {18'h03333, 18'h04444}, 2'b01, 2, 0, 1'b0);
        run_seq(18'h05555, 18'h06666, {18'h07777, 18'h08888}, 2'b11, 0, 0, 1'b1);

        // Reset in the middle of the C writes abandons the sequence
        stall_mode = 0;
        pll_locked = 1'b1;
        push_expected(18'h00A0A, 18'h00B0B, {18'h00D0D, 18'h00C0C}, 2'b11);
        cfg_n     = 18'h00A0A;
        cfg_m     = 18'h00B0B;
        cfg_c     = {18'h00D0D, 18'h00C0C};
        cfg_cmask = 2'b11;
        cfg_start = 1'b1;
        @(posedge refclk);
        #1;
        cfg_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mgmt_write && mgmt_address == 6'd5) begin
                found = 1'b1;
            end else begin
                @(posedge refclk);
                #1;
            end
        end
        check("reached_c_write", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge refclk);
        #1;
        check("abort_write_busy", {62'd0, mgmt_write, cfg_busy}, 64'd0);
        rst = 1'b0;
        @(posedge refclk);
        #1;

        // Randomised requests
        for (int s = 0; s < 10; s++) begin
            n = 18'($urandom);
            m = 18'($urandom);
            c = {18'($urandom), 18'($urandom)};
            run_seq(n, m, c, 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 1), (s == 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
